fp32_fma_arbiter: RTL and testbench

FP32_FMA_ARBITER -- requirements
Module: fp32_fma_arbiter

---
 rtl/fp32_fma_arbiter.sv | 128 ++++++++++++
 tb/tb_fp32_fma_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_fma_arbiter.sv
// Round-robin arbiter that issues requester FP32 ops to a shared FMA datapath,
// translating opcodes to sign-adjusted operand triples and tracking id/tag until the result returns.
module fp32_fma_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int FMA_LAT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*3-1:0]       req_op,
  input  logic [NUM_REQ*32-1:0]      req_src1,
  input  logic [NUM_REQ*32-1:0]      req_src2,
  input  logic [NUM_REQ*32-1:0]      req_src3,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]         req_grant,
  input  logic                       flush,
  output logic [31:0]                fma_mullhs,
  output logic [31:0]                fma_mulrhs,
  output logic [31:0]                fma_addend,
  input  logic [31:0]                fma_result,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [TAG_W-1:0]           resp_tag,
  output logic [31:0]                resp_result,
  output logic                       busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] FP_ONE   = 32'h3F80_0000;
  localparam logic [DATA_W-1:0] NEG_ZERO = 32'h8000_0000;
  localparam logic [2:0]        OP_RSVD  = 3'd7;

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] x);
    return {~x[DATA_W-1], x[DATA_W-2:0]};
  endfunction

  // Returns {mullhs, mulrhs, addend}; only the sign bit is ever altered.
  function automatic logic [3*DATA_W-1:0] xlate(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] c);
    case (op)
      3'd0:    return {a, b, c};
      3'd1:    return {a, b, neg(c)};
      3'd2:    return {neg(a), b, c};
      3'd3:    return {neg(a), b, neg(c)};
      3'd4:    return {a, b, NEG_ZERO};
      3'd5:    return {a, FP_ONE, b};
      3'd6:    return {a, FP_ONE, neg(b)};
      default: return {a, b, c};
    endcase
  endfunction

  logic [NUM_REQ-1:0]  eligible;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  int                  scan_idx;
  logic [3*DATA_W-1:0] ops_xl;
  logic [TAG_W-1:0]    gnt_tag;

  logic [FMA_LAT:0]    vld_p;
  logic [ID_W-1:0]     id_p  [0:FMA_LAT];
  logic [TAG_W-1:0]    tag_p [0:FMA_LAT];

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] && (req_op[i*3 +: 3] != OP_RSVD) && !flush && !rst;
  end

  // Scan starts at ptr and wraps; reserved opcodes are simply not eligible.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!gnt_any && eligible[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(scan_idx);
      end
    end
  end

  assign req_grant = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign ops_xl    = xlate(req_op[int'(gnt_idx)*3 +: 3],
                           req_src1[int'(gnt_idx)*DATA_W +: DATA_W],
                           req_src2[int'(gnt_idx)*DATA_W +: DATA_W],
                           req_src3[int'(gnt_idx)*DATA_W +: DATA_W]);
  assign gnt_tag   = req_tag[int'(gnt_idx)*TAG_W +: TAG_W];

  // Grant -> p0: operand registers, pointer advance and in-flight valid shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      vld_p      <= '0;
      fma_mullhs <= '0;
      fma_mulrhs <= '0;
      fma_addend <= '0;
    end else begin
      if (gnt_any)
        ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      vld_p <= flush ? '0 : {vld_p[FMA_LAT-1:0], gnt_any};
      {fma_mullhs, fma_mulrhs, fma_addend} <= gnt_any ? ops_xl : '0;
    end
  end

  always_ff @(posedge clk) begin
    id_p[0]  <= gnt_idx;
    tag_p[0] <= gnt_tag;
    for (int k = 1; k <= FMA_LAT; k++) begin
      id_p[k]  <= id_p[k-1];
      tag_p[k] <= tag_p[k-1];
    end
  end

  // p[FMA_LAT] -> response: aligned with fma_result from the datapath.
  assign resp_valid  = vld_p[FMA_LAT];
  assign resp_id     = id_p[FMA_LAT];
  assign resp_tag    = tag_p[FMA_LAT];
  assign resp_result = fma_result;
  assign busy        = |vld_p;

endmodule

// File: tb/tb_fp32_fma_arbiter.sv
// Scoreboard bench for fp32_fma_arbiter with a table-driven FMA datapath stand-in.
module tb_fp32_fma_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int FMA_LAT = 4;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*3-1:0]     req_op;
  logic [NUM_REQ*32-1:0]    req_src1, req_src2, req_src3;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_grant;
  logic                     flush;
  logic [31:0]              fma_mullhs, fma_mulrhs, fma_addend, fma_result;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [TAG_W-1:0]         resp_tag;
  logic [31:0]              resp_result;
  logic                     busy;

  fp32_fma_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .FMA_LAT(FMA_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_src3(req_src3),
    .req_tag(req_tag), .req_grant(req_grant), .flush(flush),
    .fma_mullhs(fma_mullhs), .fma_mulrhs(fma_mulrhs), .fma_addend(fma_addend),
    .fma_result(fma_result), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_result(resp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    int          tag;
    logic [31:0] res;
    int          at;
  } exp_t;
  exp_t sb[$];

  // Known products: a*b+c for the hand-worked vectors; anything else yields qNaN.
  function automatic logic [31:0] fma_model(input logic [31:0] m, input logic [31:0] r,
                                            input logic [31:0] a);
    logic [95:0] key;
    key = {m, r, a};
    case (key)
      {32'h3F800000, 32'h40000000, 32'h40400000}: return 32'h40A00000;
      {32'h3F800000, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h80000000, 32'h3F800000, 32'h80000000}: return 32'h80000000;
      {32'h3F800000, 32'h3F800000, 32'hBF800000}: return 32'h00000000;
      {32'h40400000, 32'h40000000, 32'hBF800000}: return 32'h40A00000;
      {32'hC0400000, 32'h40000000, 32'h3F800000}: return 32'hC0A00000;
      {32'hC0400000, 32'h40000000, 32'hBF800000}: return 32'hC0E00000;
      default:                                    return 32'h7FC00000;
    endcase
  endfunction

  logic [31:0] fd [1:FMA_LAT];
  always @(posedge clk) begin
    fd[1] <= fma_model(fma_mullhs, fma_mulrhs, fma_addend);
    for (int k = 2; k <= FMA_LAT; k++) fd[k] <= fd[k-1];
  end
  assign fma_result = fd[FMA_LAT];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL resp_unexpected: got id %0d tag %0d, expected no response (cycle %0d)",
                 resp_id, resp_tag, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_id", 32'(resp_id), 32'(e.id));
        check("resp_tag", 32'(resp_tag), 32'(e.tag));
        check("resp_result", resp_result, e.res);
        check("resp_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic clr_reqs();
    req_valid = '0; req_op = '0; req_src1 = '0; req_src2 = '0; req_src3 = '0;
    req_tag = '0; flush = 1'b0;
  endtask

  task automatic put(input int i, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c, input int tag);
    req_valid[i]           = 1'b1;
    req_op[i*3 +: 3]       = op;
    req_src1[i*32 +: 32]   = a;
    req_src2[i*32 +: 32]   = b;
    req_src3[i*32 +: 32]   = c;
    req_tag[i*TAG_W +: TAG_W] = TAG_W'(tag);
  endtask

  task automatic push_exp(input int id, input int tag, input logic [31:0] res);
    exp_t e;
    e.id = id; e.tag = tag; e.res = res; e.at = cyc + 1 + FMA_LAT;
    sb.push_back(e);
  endtask

  // Called at a negedge with only requester i valid; returns at the next negedge.
  task automatic issue(input int i, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input int tag,
                       input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
                       input logic [31:0] res, input bit track);
    logic [NUM_REQ-1:0] g;
    clr_reqs();
    put(i, op, a, b, c, tag);
    #1;
    g = '0; g[i] = 1'b1;
    check("grant_single", 32'(req_grant), 32'(g));
    if (track) push_exp(i, tag, res);
    @(posedge clk); #1;
    check("fma_mullhs", fma_mullhs, e1);
    check("fma_mulrhs", fma_mulrhs, e2);
    check("fma_addend", fma_addend, e3);
    @(negedge clk);
    clr_reqs();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [NUM_REQ-1:0] g;
    rst = 1'b1;
    clr_reqs();
    put(0, 3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1);
    @(negedge clk); #1;
    check("rst_grant", 32'(req_grant), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fma_mullhs", fma_mullhs, 32'd0);
    check("rst_fma_addend", fma_addend, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single FMADD 1*2+3 = 5
    issue(0, 3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 5,
          32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000, 1'b1);
    #1 check("busy_inflight", 32'(busy), 32'd1);
    repeat (8) @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);

    // Reset pulse brings the pointer back to 0, then four continuous FADDs.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr_reqs();
    for (int i = 0; i < NUM_REQ; i++)
      put(i, 3'd5, 32'h3F800000, 32'h3F800000, 32'h0, 10 + i);
    for (int k = 0; k < 8; k++) begin
      #1;
      g = '0; g[k % NUM_REQ] = 1'b1;
      check("grant_rr", 32'(req_grant), 32'(g));
      push_exp(k % NUM_REQ, 10 + (k % NUM_REQ), 32'h40000000);
      @(negedge clk);
    end
    clr_reqs();
    repeat (6) @(negedge clk);

    // FMUL -0*1, FSUB 1-1, then FMSUB/FNMSUB/FNMADD back to back.
    issue(2, 3'd4, 32'h80000000, 32'h3F800000, 32'h12345678, 20,
          32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000, 1'b1);
    issue(3, 3'd6, 32'h3F800000, 32'h3F800000, 32'h0, 21,
          32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b1);
    issue(0, 3'd1, 32'h40400000, 32'h40000000, 32'h3F800000, 22,
          32'h40400000, 32'h40000000, 32'hBF800000, 32'h40A00000, 1'b1);
    issue(1, 3'd2, 32'h40400000, 32'h40000000, 32'h3F800000, 23,
          32'hC0400000, 32'h40000000, 32'h3F800000, 32'hC0A00000, 1'b1);
    issue(2, 3'd3, 32'h40400000, 32'h40000000, 32'h3F800000, 24,
          32'hC0400000, 32'h40000000, 32'hBF800000, 32'hC0E00000, 1'b1);
    repeat (7) @(negedge clk);

    // Reserved opcode on req 1 neither wins nor blocks req 2 (pointer is at 3).
    clr_reqs();
    put(1, 3'd7, 32'h3F800000, 32'h3F800000, 32'h3F800000, 30);
    put(2, 3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 31);
    #1 check("grant_skip_rsvd", 32'(req_grant), 32'b0100);
    push_exp(2, 31, 32'h40A00000);
    @(negedge clk);
    clr_reqs();
    put(1, 3'd7, 32'h3F800000, 32'h3F800000, 32'h3F800000, 30);
    #1 check("grant_rsvd_alone", 32'(req_grant), 32'd0);
    @(negedge clk);
    clr_reqs();
    repeat (6) @(negedge clk);

    // Three grants, flush as the first returns; the other two are killed.
    issue(3, 3'd5, 32'h3F800000, 32'h3F800000, 32'h0, 40,
          32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
    issue(0, 3'd5, 32'h3F800000, 32'h3F800000, 32'h0, 41,
          32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);
    issue(1, 3'd5, 32'h3F800000, 32'h3F800000, 32'h0, 42,
          32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    put(2, 3'd5, 32'h3F800000, 32'h3F800000, 32'h0, 43);
    #1;
    check("flush_no_grant", 32'(req_grant), 32'd0);
    check("flush_resp_same_cycle", 32'(resp_valid), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 check("busy_after_flush", 32'(busy), 32'd0);
    issue(2, 3'd5, 32'h3F800000, 32'h3F800000, 32'h0, 43,
          32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
    repeat (7) @(negedge clk);

    // Reset two cycles after a grant discards the operation.
    clr_reqs();
    put(0, 3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 50);
    #1 check("grant_before_rst", 32'(req_grant), 32'b0001);
    @(negedge clk);
    clr_reqs();
    @(negedge clk);
    put(0, 3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 51);
    #2 rst = 1'b1;
    #1;
    check("midrst_grant", 32'(req_grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_fma_mulrhs", fma_mulrhs, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clr_reqs();
    repeat (10) @(negedge clk);
    check("busy_end", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
